// File: rtl/sram_burst_controller.sv
`default_nettype none
// ============================================================================
// Module   : sram_burst_controller
// Purpose  : Bridges one DATA_W-bit MEM-stage access onto an asynchronous
//            SRAM with a narrower SRAM_DW-bit bus. The access is split into
//            BEATS = DATA_W/SRAM_DW beats, lowest beat first. Each beat is one
//            setup cycle followed by WAIT_CYCLES strobe cycles. ready is held
//            low to freeze the pipeline until the access has completed.
// Ports    : clk, rstN (synchronous, active-low)
//            wrEn, rdEn, address, writeData   - CPU request (held while ready=0)
//            byteEn                           - write byte enables (optional)
//            readData, ready                  - CPU response
//            SRAM_DQ (inout), SRAM_ADDR       - SRAM data / word address
//            SRAM_UB_N/LB_N/WE_N/CE_N/OE_N    - SRAM controls, active-low
// Options  : define SRAM_BYTE_MASK_EN to add the byteEn input and drive the
//            SRAM byte lanes from it on writes (requires SRAM_DW = 16).
//            Without it SRAM_UB_N and SRAM_LB_N are tied low.
// Revision : 1.0  initial release
// ============================================================================
module sram_burst_controller #(
  parameter int DATA_W      = 32,
  parameter int SRAM_DW     = 16,
  parameter int SRAM_AW     = 18,
  parameter int WAIT_CYCLES = 1,
  parameter int ADDR_BASE   = 1024
) (
  input  logic                clk,
  input  logic                rstN,
  input  logic                wrEn,
  input  logic                rdEn,
  input  logic [31:0]         address,
  input  logic [DATA_W-1:0]   writeData,
`ifdef SRAM_BYTE_MASK_EN
  input  logic [DATA_W/8-1:0] byteEn,
`endif
  output logic [DATA_W-1:0]   readData,
  output logic                ready,
  inout  wire  [SRAM_DW-1:0]  SRAM_DQ,
  output logic [SRAM_AW-1:0]  SRAM_ADDR,
  output logic                SRAM_UB_N,
  output logic                SRAM_LB_N,
  output logic                SRAM_WE_N,
  output logic                SRAM_CE_N,
  output logic                SRAM_OE_N
);

  localparam int BEATS      = DATA_W / SRAM_DW;
  localparam int BYTE_SHIFT = $clog2(SRAM_DW / 8);
  localparam int BEAT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int WAIT_W     = $clog2(WAIT_CYCLES + 1);
  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BEATS - 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(WAIT_CYCLES);

  // Elaboration-time parameter checks
  if ((DATA_W % SRAM_DW) != 0) begin : g_err_width
    $error("DATA_W must be an integer multiple of SRAM_DW");
  end
  if (WAIT_CYCLES < 1) begin : g_err_wait
    $error("WAIT_CYCLES must be at least 1");
  end
`ifdef SRAM_BYTE_MASK_EN
  if (SRAM_DW != 16) begin : g_err_mask
    $error("SRAM_BYTE_MASK_EN requires SRAM_DW = 16");
  end
`endif

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_TURN   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic                wr_q, wr_d;           // latched op: 1 = write
  logic [SRAM_AW-1:0]  addr_q, addr_d;       // current beat word address
  logic [DATA_W-1:0]   wshift_q, wshift_d;   // write data, current beat in low lane
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [BEAT_W-1:0]   beat_q, beat_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;       // 0 = setup, 1..WAIT_CYCLES = strobe
`ifdef SRAM_BYTE_MASK_EN
  logic [DATA_W/8-1:0] beshift_q, beshift_d; // byte enables, current beat in low bits
`endif

  logic               w_req;
  logic [31:0]        w_off;
  logic [SRAM_AW-1:0] w_base;
  logic               w_in_access;
  logic               w_strobe;
  logic               w_beat_en;

  assign w_req       = wrEn | rdEn;
  // Byte offset from the SRAM window, converted to a word index; the
  // truncation to SRAM_AW bits gives the modulo-2^SRAM_AW wrap.
  assign w_off       = address - 32'(ADDR_BASE);
  assign w_base      = SRAM_AW'(w_off >> BYTE_SHIFT);
  assign w_in_access = (state_q == S_ACCESS);
  assign w_strobe    = w_in_access && (wait_q != '0);

`ifdef SRAM_BYTE_MASK_EN
  // A fully masked beat still spends its cycles but never asserts WE_N.
  assign w_beat_en = |beshift_q[1:0];
  assign SRAM_LB_N = (w_in_access && wr_q) ? ~beshift_q[0] : 1'b0;
  assign SRAM_UB_N = (w_in_access && wr_q) ? ~beshift_q[1] : 1'b0;
`else
  assign w_beat_en = 1'b1;
  assign SRAM_LB_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
`endif

  assign SRAM_CE_N = ~w_in_access;
  assign SRAM_OE_N = ~(w_in_access && !wr_q);
  assign SRAM_WE_N = ~(w_strobe && wr_q && w_beat_en);
  assign SRAM_ADDR = addr_q;
  assign readData  = rdata_q;
  assign ready     = ((state_q == S_IDLE) && !w_req) || (state_q == S_DONE);

  // Bus released while reset is asserted so no contention during recovery.
  assign SRAM_DQ = (rstN && w_in_access && wr_q) ? wshift_q[SRAM_DW-1:0] : 'z;

  always_comb begin
    state_d  = state_q;
    wr_d     = wr_q;
    addr_d   = addr_q;
    wshift_d = wshift_q;
    rdata_d  = rdata_q;
    beat_d   = beat_q;
    wait_d   = wait_q;
`ifdef SRAM_BYTE_MASK_EN
    beshift_d = beshift_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (w_req) begin
          state_d  = S_ACCESS;
          wr_d     = wrEn;        // write wins when both are requested
          addr_d   = w_base;
          wshift_d = writeData;
          beat_d   = '0;
          wait_d   = '0;
`ifdef SRAM_BYTE_MASK_EN
          beshift_d = byteEn;
`endif
        end
      end
      S_ACCESS: begin
        if (wait_q == WAIT_LAST) begin
          if (!wr_q) begin
            rdata_d[int'(beat_q)*SRAM_DW +: SRAM_DW] = SRAM_DQ;
          end
          wait_d = '0;
          if (beat_q == BEAT_LAST) begin
            state_d = S_TURN;
          end else begin
            // Next beat's setup cycle: present the new address and data.
            beat_d   = beat_q + 1'b1;
            addr_d   = addr_q + 1'b1;
            wshift_d = wshift_q >> SRAM_DW;
`ifdef SRAM_BYTE_MASK_EN
            beshift_d = beshift_q >> (SRAM_DW / 8);
`endif
          end
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      S_TURN:  state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstN) begin
      state_q  <= S_IDLE;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wshift_q <= '0;
      rdata_q  <= '0;
      beat_q   <= '0;
      wait_q   <= '0;
`ifdef SRAM_BYTE_MASK_EN
      beshift_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wshift_q <= wshift_d;
      rdata_q  <= rdata_d;
      beat_q   <= beat_d;
      wait_q   <= wait_d;
`ifdef SRAM_BYTE_MASK_EN
      beshift_q <= beshift_d;
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sram_burst_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_burst_controller
// Purpose  : Self-checking bench for sram_burst_controller with a behavioural
//            async SRAM, a directed vector table, a mid-burst reset sequence
//            and randomized accesses checked against a word-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_sram_burst_controller;

  localparam int DATA_W      = 32;
  localparam int SRAM_DW     = 16;
  localparam int SRAM_AW     = 18;
  localparam int WAIT_CYCLES = 1;
  localparam int ADDR_BASE   = 1024;
  localparam int BEATS       = DATA_W / SRAM_DW;
  localparam int STALL       = 1 + BEATS * (WAIT_CYCLES + 1) + 1;
  localparam int MEM_WORDS   = 1 << SRAM_AW;

  logic                clk = 1'b0;
  logic                rstN;
  logic                wrEn, rdEn;
  logic [31:0]         address;
  logic [DATA_W-1:0]   writeData;
  logic [DATA_W-1:0]   readData;
  logic                ready;
  wire  [SRAM_DW-1:0]  SRAM_DQ;
  logic [SRAM_AW-1:0]  SRAM_ADDR;
  logic                SRAM_UB_N, SRAM_LB_N, SRAM_WE_N, SRAM_CE_N, SRAM_OE_N;
`ifdef SRAM_BYTE_MASK_EN
  logic [DATA_W/8-1:0] byteEn;
`endif

  always #5 clk = ~clk;

  sram_burst_controller #(
    .DATA_W(DATA_W), .SRAM_DW(SRAM_DW), .SRAM_AW(SRAM_AW),
    .WAIT_CYCLES(WAIT_CYCLES), .ADDR_BASE(ADDR_BASE)
  ) dut (
    .clk(clk), .rstN(rstN), .wrEn(wrEn), .rdEn(rdEn),
    .address(address), .writeData(writeData),
`ifdef SRAM_BYTE_MASK_EN
    .byteEn(byteEn),
`endif
    .readData(readData), .ready(ready), .SRAM_DQ(SRAM_DQ),
    .SRAM_ADDR(SRAM_ADDR), .SRAM_UB_N(SRAM_UB_N), .SRAM_LB_N(SRAM_LB_N),
    .SRAM_WE_N(SRAM_WE_N), .SRAM_CE_N(SRAM_CE_N), .SRAM_OE_N(SRAM_OE_N)
  );

  // ---------------- behavioural async SRAM ----------------
  logic [15:0] mem [0:MEM_WORDS-1];
  logic        mem_clr;

  always @(posedge clk) begin
    if (mem_clr) begin
      for (int i = 0; i < MEM_WORDS; i++) mem[i] <= '0;
    end else if (!SRAM_CE_N && !SRAM_WE_N) begin
      if (!SRAM_LB_N) mem[SRAM_ADDR][7:0]  <= SRAM_DQ[7:0];
      if (!SRAM_UB_N) mem[SRAM_ADDR][15:8] <= SRAM_DQ[15:8];
    end
  end

  // SRAM drives on reads; while deselected the bench holds the bus at zero so
  // any stray controller drive becomes visible.
  wire sram_drv = SRAM_CE_N | (~SRAM_OE_N & SRAM_WE_N);
  assign SRAM_DQ = sram_drv ? (SRAM_CE_N ? 16'h0000 : mem[SRAM_ADDR]) : 16'hzzzz;

  // ---------------- reference model ----------------
  logic [15:0] ref_mem [0:MEM_WORDS-1];
  logic [31:0] exp_rd;

  function automatic logic [SRAM_AW-1:0] word_of(input logic [31:0] a, input int i);
    logic [31:0] off;
    off = a - 32'(ADDR_BASE);
    return SRAM_AW'((off / (SRAM_DW / 8)) + 32'(i));
  endfunction

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full CPU access: request held until ready, then model checks.
  task automatic run_op(input logic wr, input logic rd, input logic [31:0] a,
                        input logic [31:0] wd, input string tag);
    int low, viol, ce_cycles;
    logic ok;
    logic [SRAM_AW-1:0] strobe_q[$];
    logic [SRAM_AW-1:0] exp_q[$];
    @(negedge clk);
    wrEn = wr; rdEn = rd; address = a; writeData = wd;
    #1;
    low = 0; viol = 0; ce_cycles = 0;
    while (!ready && low < 100) begin
      low++;
      if (SRAM_CE_N) begin
        if (SRAM_DQ !== 16'h0000) viol++;
      end else begin
        ce_cycles++;
        if (wr) begin
          if (!SRAM_OE_N) viol++;
          if (!SRAM_WE_N) strobe_q.push_back(SRAM_ADDR);
        end else begin
          if (!SRAM_WE_N || SRAM_OE_N) viol++;
          if (SRAM_DQ !== mem[SRAM_ADDR]) viol++;
        end
      end
      @(negedge clk); #1;
    end
    check({tag, "_stall"}, 64'(low), 64'(STALL));
    check({tag, "_ce_cycles"}, 64'(ce_cycles), 64'(BEATS * (WAIT_CYCLES + 1)));
    check({tag, "_bus_ctrl"}, 64'(viol), 64'd0);
    if (!wr) begin
      for (int i = 0; i < BEATS; i++) exp_rd[i*SRAM_DW +: SRAM_DW] = ref_mem[word_of(a, i)];
    end
    check({tag, "_readData"}, 64'(readData), 64'(exp_rd));
    wrEn = 1'b0; rdEn = 1'b0;
    if (wr) begin
      for (int i = 0; i < BEATS; i++) begin
        ref_mem[word_of(a, i)] = wd[i*SRAM_DW +: SRAM_DW];
        for (int w = 0; w < WAIT_CYCLES; w++) exp_q.push_back(word_of(a, i));
      end
      ok = (strobe_q.size() == exp_q.size());
      if (ok) for (int i = 0; i < exp_q.size(); i++) if (strobe_q[i] !== exp_q[i]) ok = 1'b0;
      check({tag, "_strobe_addrs"}, 64'(ok), 64'd1);
      for (int i = 0; i < BEATS; i++)
        check({tag, "_mem_word"}, 64'(mem[word_of(a, i)]), 64'(ref_mem[word_of(a, i)]));
    end
  endtask

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic [17:0] wa0;
    logic [15:0] we0;
    logic [17:0] wa1;
    logic [15:0] we1;
  } vec_t;

  vec_t vecs [6];

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 1'b0, 32'd1032,   32'hDEADBEEF, 32'h00000000, 18'd4,       16'hBEEF, 18'd5, 16'hDEAD};
    vecs[1] = '{1'b0, 1'b1, 32'd1032,   32'h13579BDF, 32'hDEADBEEF, 18'd4,       16'hBEEF, 18'd5, 16'hDEAD};
    vecs[2] = '{1'b1, 1'b1, 32'd1024,   32'h12345678, 32'hDEADBEEF, 18'd0,       16'h5678, 18'd1, 16'h1234};
    vecs[3] = '{1'b1, 1'b0, 32'd525310, 32'hCAFEF00D, 32'hDEADBEEF, 18'h3FFFF,   16'hF00D, 18'd0, 16'hCAFE};
    vecs[4] = '{1'b0, 1'b1, 32'd525310, 32'h00000000, 32'hCAFEF00D, 18'h3FFFF,   16'hF00D, 18'd0, 16'hCAFE};
    vecs[5] = '{1'b0, 1'b1, 32'd1025,   32'hFFFFFFFF, 32'h1234CAFE, 18'd0,       16'hCAFE, 18'd1, 16'h1234};

    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = '0;
    exp_rd = '0;

    // ---- reset ----
    rstN = 1'b0; mem_clr = 1'b1;
    wrEn = 1'b0; rdEn = 1'b0; address = '0; writeData = '0;
`ifdef SRAM_BYTE_MASK_EN
    byteEn = '1;
`endif
    repeat (3) @(negedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'd1);
    check("rst_ctrl_we_ce_oe", 64'({SRAM_WE_N, SRAM_CE_N, SRAM_OE_N}), 64'b111);
    check("rst_ub_lb", 64'({SRAM_UB_N, SRAM_LB_N}), 64'b00);
    check("rst_sram_addr", 64'(SRAM_ADDR), 64'd0);
    check("rst_readData", 64'(readData), 64'd0);
    mem_clr = 1'b0;
    rstN = 1'b1;

    // ---- directed vector table ----
    for (int v = 0; v < 6; v++) begin
      run_op(vecs[v].wr, vecs[v].rd, vecs[v].addr, vecs[v].wd, $sformatf("vec%0d", v));
      check($sformatf("vec%0d_table_readData", v), 64'(readData), 64'(vecs[v].exp_rd));
      check($sformatf("vec%0d_table_word_a", v), 64'(mem[vecs[v].wa0]), 64'(vecs[v].we0));
      check($sformatf("vec%0d_table_word_b", v), 64'(mem[vecs[v].wa1]), 64'(vecs[v].we1));
    end

    // ---- reset on the 3rd ACCESS cycle of a write to 1064 (words 20/21) ----
    @(negedge clk);
    wrEn = 1'b1; address = 32'd1064; writeData = 32'h11112222;
    repeat (3) @(negedge clk);
    #1;
    check("midrst_setup_beat1_addr", 64'(SRAM_ADDR), 64'd21);
    check("midrst_setup_beat1_ce_we", 64'({SRAM_CE_N, SRAM_WE_N}), 64'b01);
    rstN = 1'b0; wrEn = 1'b0;
    @(negedge clk); #1;
    check("midrst_ctrl_we_ce_oe", 64'({SRAM_WE_N, SRAM_CE_N, SRAM_OE_N}), 64'b111);
    check("midrst_ready", 64'(ready), 64'd1);
    check("midrst_dq_released", 64'(SRAM_DQ), 64'h0);
    check("midrst_addr_rd", 64'({SRAM_ADDR, readData}), 64'd0);
    rstN = 1'b1;
    check("midrst_word20", 64'(mem[20]), 64'h2222);
    check("midrst_word21", 64'(mem[21]), 64'(ref_mem[21]));
    ref_mem[20] = 16'h2222;
    exp_rd = '0;

`ifdef SRAM_BYTE_MASK_EN
    // ---- byte-masked write: only beat 1 low byte ----
    begin
      int n, strobes;
      logic lanes_ok;
      @(negedge clk);
      wrEn = 1'b1; address = 32'd1224; writeData = 32'hAABBCCDD; byteEn = 4'b0100;
      #1;
      n = 0; strobes = 0; lanes_ok = 1'b1;
      while (!ready && n < 100) begin
        n++;
        if (!SRAM_WE_N) begin
          strobes++;
          if (SRAM_ADDR !== 18'd101 || SRAM_UB_N !== 1'b1 || SRAM_LB_N !== 1'b0) lanes_ok = 1'b0;
        end
        @(negedge clk); #1;
      end
      wrEn = 1'b0; byteEn = '1;
      check("mask_stall", 64'(n), 64'(STALL));
      check("mask_strobes", 64'(strobes), 64'(WAIT_CYCLES));
      check("mask_lanes", 64'(lanes_ok), 64'd1);
      check("mask_word100", 64'(mem[100]), 64'(ref_mem[100]));
      check("mask_word101", 64'(mem[101]), 64'({ref_mem[101][15:8], 8'hBB}));
      ref_mem[101][7:0] = 8'hBB;
    end
`endif

    // ---- randomized accesses against the model ----
    for (int k = 0; k < 40; k++) begin
      logic wr, rd;
      logic [31:0] a;
      int r, s;
      r  = int'($urandom_range(0, 9));
      wr = (r < 4) || (r == 9);
      rd = (r >= 4);
      s  = int'($urandom_range(0, 9));
      if (s < 7)       a = 32'(ADDR_BASE) + $urandom_range(0, 63);
      else if (s == 7) a = 32'd525310 - $urandom_range(0, 5);
      else if (s == 8) a = $urandom_range(0, 1023);
      else             a = $urandom();
      run_op(wr, rd, a, $urandom(), $sformatf("rnd%0d", k));
    end

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
